hazard3_operand_bypass: RTL and testbench

- Sits directly downstream of the 1-write/2-read register file.
- Steers the regfile read addresses and aligns them with the one-cycle registered read data.
- Resolves read-after-write hazards by forwarding from the execute-stage result, the writeback port, and a captured copy of the previous cycle's write.
- Holds the operand stage and stalls decode on load-use hazards, re-reading the regfile every held cycle so stale data never reaches execute.

---
 rtl/hazard3_operand_bypass.sv | 160 ++++++++++++++++
 tb/tb_hazard3_operand_bypass.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_operand_bypass.sv
// Operand bypass stage between the 1W/2R register file and execute.
// Steers regfile read addresses, aligns them with the registered read data,
// and resolves read-after-write hazards. Operands come from the execute
// result, the writeback port, a copy of the previous cycle's write, or the
// regfile. A load still in flight in execute holds this stage and stalls
// decode; the regfile is re-read every held cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   d_valid_i/d_ready_o   decode handshake (d_ready_o is combinational)
//   d_raddr1_i/2_i        decode rs1/rs2 addresses
//   rf_raddr1_o/2_o       regfile read addresses (combinational)
//   rf_rdata1_i/2_i       regfile read data, one cycle after the address
//   x_wen_i, x_waddr_i, x_wdata_i, x_wdata_valid_i   execute-stage producer
//   wb_wen_i, wb_waddr_i, wb_wdata_i                 regfile write port
//   op_valid_o/op_ready_i execute handshake (op_valid_o is combinational)
//   op_rs1_o/op_rs2_o     resolved operands (combinational)
module hazard3_operand_bypass #(
    parameter int unsigned W_DATA = 32,
    parameter int unsigned N_REGS = 16,
    parameter int unsigned W_ADDR = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              d_valid_i,
    output logic              d_ready_o,
    input  logic [W_ADDR-1:0] d_raddr1_i,
    input  logic [W_ADDR-1:0] d_raddr2_i,

    output logic [W_ADDR-1:0] rf_raddr1_o,
    output logic [W_ADDR-1:0] rf_raddr2_o,
    input  logic [W_DATA-1:0] rf_rdata1_i,
    input  logic [W_DATA-1:0] rf_rdata2_i,

    input  logic              x_wen_i,
    input  logic [W_ADDR-1:0] x_waddr_i,
    input  logic [W_DATA-1:0] x_wdata_i,
    input  logic              x_wdata_valid_i,

    input  logic              wb_wen_i,
    input  logic [W_ADDR-1:0] wb_waddr_i,
    input  logic [W_DATA-1:0] wb_wdata_i,

    output logic              op_valid_o,
    input  logic              op_ready_i,
    output logic [W_DATA-1:0] op_rs1_o,
    output logic [W_DATA-1:0] op_rs2_o
);

    // Register count must be addressable with W_ADDR bits.
    if (N_REGS > (32'd1 << W_ADDR)) begin : g_cfg_check
        $error("hazard3_operand_bypass: N_REGS does not fit in W_ADDR bits");
    end

    logic              occ_q, occ_d;
    logic [W_ADDR-1:0] hold_raddr1_q, hold_raddr1_d;
    logic [W_ADDR-1:0] hold_raddr2_q, hold_raddr2_d;
    logic              pw_valid_q, pw_valid_d;
    logic [W_ADDR-1:0] pw_addr_q, pw_addr_d;
    logic [W_DATA-1:0] pw_data_q, pw_data_d;

    logic              hazard_c;
    logic              advance_c;
    logic              accept_c;

    // Forwarding priority: x0, execute, writeback, previous write, regfile.
    function automatic logic [W_DATA-1:0] resolve(
        input logic [W_ADDR-1:0] addr,
        input logic [W_DATA-1:0] rf_data,
        input logic              x_wen,
        input logic [W_ADDR-1:0] x_waddr,
        input logic [W_DATA-1:0] x_wdata,
        input logic              wb_wen,
        input logic [W_ADDR-1:0] wb_waddr,
        input logic [W_DATA-1:0] wb_wdata,
        input logic              pw_valid,
        input logic [W_ADDR-1:0] pw_addr,
        input logic [W_DATA-1:0] pw_data
    );
        logic [W_DATA-1:0] res;
        if (addr == '0) begin
            res = '0;
        end else if (x_wen && (x_waddr == addr)) begin
            res = x_wdata;
        end else if (wb_wen && (wb_waddr == addr)) begin
            res = wb_wdata;
        end else if (pw_valid && (pw_addr == addr)) begin
            res = pw_data;
        end else begin
            res = rf_data;
        end
        return res;
    endfunction

    // Load-use hazard: a not-yet-final execute result feeds a held operand.
    always_comb begin
        hazard_c = 1'b0;
        if (occ_q && x_wen_i && (x_waddr_i != '0) && !x_wdata_valid_i &&
            ((x_waddr_i == hold_raddr1_q) || (x_waddr_i == hold_raddr2_q))) begin
            hazard_c = 1'b1;
        end
    end

    assign op_valid_o = occ_q && !hazard_c;
    assign advance_c  = op_valid_o && op_ready_i;
    assign d_ready_o  = !occ_q || advance_c;
    assign accept_c   = d_valid_i && d_ready_o;

    // Re-read the held addresses while stalled so read data tracks the regfile.
    assign rf_raddr1_o = d_ready_o ? d_raddr1_i : hold_raddr1_q;
    assign rf_raddr2_o = d_ready_o ? d_raddr2_i : hold_raddr2_q;

    assign op_rs1_o = resolve(hold_raddr1_q, rf_rdata1_i,
                              x_wen_i, x_waddr_i, x_wdata_i,
                              wb_wen_i, wb_waddr_i, wb_wdata_i,
                              pw_valid_q, pw_addr_q, pw_data_q);
    assign op_rs2_o = resolve(hold_raddr2_q, rf_rdata2_i,
                              x_wen_i, x_waddr_i, x_wdata_i,
                              wb_wen_i, wb_waddr_i, wb_wdata_i,
                              pw_valid_q, pw_addr_q, pw_data_q);

    // Next-state: stage occupancy, held addresses, previous-write capture.
    always_comb begin
        occ_d         = occ_q;
        hold_raddr1_d = hold_raddr1_q;
        hold_raddr2_d = hold_raddr2_q;
        if (accept_c) begin
            occ_d         = 1'b1;
            hold_raddr1_d = d_raddr1_i;
            hold_raddr2_d = d_raddr2_i;
        end else if (advance_c) begin
            occ_d = 1'b0;
        end
        // A same-cycle regfile read returns the old value; keep the write.
        pw_valid_d = wb_wen_i && (wb_waddr_i != '0);
        pw_addr_d  = wb_waddr_i;
        pw_data_d  = wb_wdata_i;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q         <= 1'b0;
            hold_raddr1_q <= '0;
            hold_raddr2_q <= '0;
            pw_valid_q    <= 1'b0;
            pw_addr_q     <= '0;
            pw_data_q     <= '0;
        end else begin
            occ_q         <= occ_d;
            hold_raddr1_q <= hold_raddr1_d;
            hold_raddr2_q <= hold_raddr2_d;
            pw_valid_q    <= pw_valid_d;
            pw_addr_q     <= pw_addr_d;
            pw_data_q     <= pw_data_d;
        end
    end

endmodule

// File: tb/tb_hazard3_operand_bypass.sv
// Testbench for hazard3_operand_bypass: per-cycle vector table with a
// regfile model and an operand scoreboard, plus a reset-mid-hold sequence.
module tb_hazard3_operand_bypass;

    localparam int unsigned W_DATA = 32;
    localparam int unsigned W_ADDR = 5;
    localparam int unsigned N_VEC  = 14;

    logic              clk;
    logic              rst_n;
    logic              d_valid, d_ready;
    logic [W_ADDR-1:0] d_raddr1, d_raddr2;
    logic [W_ADDR-1:0] rf_raddr1, rf_raddr2;
    logic [W_DATA-1:0] rf_rdata1, rf_rdata2;
    logic              x_wen, x_wdata_valid;
    logic [W_ADDR-1:0] x_waddr;
    logic [W_DATA-1:0] x_wdata;
    logic              wb_wen;
    logic [W_ADDR-1:0] wb_waddr;
    logic [W_DATA-1:0] wb_wdata;
    logic              op_valid, op_ready;
    logic [W_DATA-1:0] op_rs1, op_rs2;

    hazard3_operand_bypass #(
        .W_DATA(32), .N_REGS(16), .W_ADDR(5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .d_valid_i      (d_valid),
        .d_ready_o      (d_ready),
        .d_raddr1_i     (d_raddr1),
        .d_raddr2_i     (d_raddr2),
        .rf_raddr1_o    (rf_raddr1),
        .rf_raddr2_o    (rf_raddr2),
        .rf_rdata1_i    (rf_rdata1),
        .rf_rdata2_i    (rf_rdata2),
        .x_wen_i        (x_wen),
        .x_waddr_i      (x_waddr),
        .x_wdata_i      (x_wdata),
        .x_wdata_valid_i(x_wdata_valid),
        .wb_wen_i       (wb_wen),
        .wb_waddr_i     (wb_waddr),
        .wb_wdata_i     (wb_wdata),
        .op_valid_o     (op_valid),
        .op_ready_i     (op_ready),
        .op_rs1_o       (op_rs1),
        .op_rs2_o       (op_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model: registered read returns the pre-write value.
    logic [W_DATA-1:0] mem [0:15];

    function automatic logic [W_DATA-1:0] mem_init(input int i);
        case (i)
            0:       return 32'h0;
            3:       return 32'h11;
            4:       return 32'h22;
            5:       return 32'h0;
            7:       return 32'h77;
            9:       return 32'h99;
            default: return 32'h100 + 32'(i);
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= mem_init(i);
            rf_rdata1 <= '0;
            rf_rdata2 <= '0;
        end else begin
            rf_rdata1 <= mem[rf_raddr1[3:0]];
            rf_rdata2 <= mem[rf_raddr2[3:0]];
            if (wb_wen && (wb_waddr != '0)) mem[wb_waddr[3:0]] <= wb_wdata;
        end
    end

    typedef struct {
        logic              dv;
        logic [W_ADDR-1:0] a1, a2;
        logic              ordy;
        logic              xw;
        logic [W_ADDR-1:0] xa;
        logic [W_DATA-1:0] xd;
        logic              xv;
        logic              ww;
        logic [W_ADDR-1:0] wa;
        logic [W_DATA-1:0] wd;
        logic              e_drdy;
        logic              e_ovld;
        logic [W_DATA-1:0] e_rs1, e_rs2;
    } vec_t;

    typedef struct {
        logic [W_DATA-1:0] rs1, rs2;
    } exp_t;

    vec_t              vecs [N_VEC];
    exp_t              sb [$];
    int                n_cmp;
    int                n_bad;
    logic [W_ADDR-1:0] m_hold1, m_hold2;

    function automatic vec_t mk(
        input logic dv, input int a1, input int a2, input logic ordy,
        input logic xw, input int xa, input logic [31:0] xd, input logic xv,
        input logic ww, input int wa, input logic [31:0] wd,
        input logic e_drdy, input logic e_ovld,
        input logic [31:0] e_rs1, input logic [31:0] e_rs2);
        vec_t v;
        v.dv = dv; v.a1 = 5'(a1); v.a2 = 5'(a2); v.ordy = ordy;
        v.xw = xw; v.xa = 5'(xa); v.xd = xd; v.xv = xv;
        v.ww = ww; v.wa = 5'(wa); v.wd = wd;
        v.e_drdy = e_drdy; v.e_ovld = e_ovld; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        d_valid = v.dv; d_raddr1 = v.a1; d_raddr2 = v.a2; op_ready = v.ordy;
        x_wen = v.xw; x_waddr = v.xa; x_wdata = v.xd; x_wdata_valid = v.xv;
        wb_wen = v.ww; wb_waddr = v.wa; wb_wdata = v.wd;
    endtask

    // Compare operands against the scoreboard head: pop on handoff, peek while held.
    task automatic check_operands(input string tag);
        exp_t e;
        if (op_valid) begin
            if (sb.size() == 0) begin
                if (op_ready) check({tag, " unexpected_delivery"}, 32'd1, 32'd0);
            end else begin
                e = sb[0];
                check({tag, " op_rs1"}, op_rs1, e.rs1);
                check({tag, " op_rs2"}, op_rs2, e.rs2);
                if (op_ready) void'(sb.pop_front());
            end
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        exp_t  e;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        drive(v);
        #2;
        check({tag, " d_ready"}, 32'(d_ready), 32'(v.e_drdy));
        check({tag, " op_valid"}, 32'(op_valid), 32'(v.e_ovld));
        check({tag, " rf_raddr1"}, 32'(rf_raddr1), 32'(v.e_drdy ? v.a1 : m_hold1));
        check({tag, " rf_raddr2"}, 32'(rf_raddr2), 32'(v.e_drdy ? v.a2 : m_hold2));
        check_operands(tag);
        if (v.dv && v.e_drdy) begin
            m_hold1 = v.a1;
            m_hold2 = v.a2;
            e.rs1 = v.e_rs1;
            e.rs2 = v.e_rs2;
            sb.push_back(e);
        end
    endtask

    initial begin
        exp_t e;
        n_cmp = 0; n_bad = 0;
        m_hold1 = '0; m_hold2 = '0;
        rst_n = 1'b0;
        drive(mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0));

        //        dv a1 a2 rdy xw xa xd            xv ww wa wd              drdy ovld rs1        rs2
        vecs[0]  = mk(1, 3, 4, 1, 0, 0, 32'h0,    0, 0, 0, 32'h0,    1, 0, 32'h11,  32'h22);
        vecs[1]  = mk(1, 5, 4, 1, 0, 0, 32'h0,    0, 1, 5, 32'hAA,   1, 1, 32'hAA,  32'h22);
        vecs[2]  = mk(1, 7, 2, 1, 0, 0, 32'h0,    0, 0, 0, 32'h0,    1, 1, 32'hBB,  32'h102);
        vecs[3]  = mk(1, 8, 9, 1, 1, 7, 32'hBB,   1, 1, 7, 32'hCC,   1, 1, 32'h108, 32'h1234);
        vecs[4]  = mk(1, 1, 2, 1, 1, 9, 32'hDEAD, 0, 0, 0, 32'h0,    0, 0, 32'h0,   32'h0);
        vecs[5]  = mk(1, 1, 2, 1, 1, 9, 32'hDEAD, 0, 0, 0, 32'h0,    0, 0, 32'h0,   32'h0);
        vecs[6]  = mk(1, 0, 9, 1, 0, 0, 32'h0,    0, 1, 9, 32'h1234, 1, 1, 32'h0,   32'h1234);
        vecs[7]  = mk(1, 3, 4, 1, 1, 0, 32'hFF,   0, 0, 0, 32'h0,    1, 1, 32'h11,  32'h22);
        vecs[8]  = mk(1, 1, 2, 0, 0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 1, 32'h0,   32'h0);
        vecs[9]  = mk(1, 1, 2, 0, 0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 1, 32'h0,   32'h0);
        vecs[10] = mk(1, 1, 2, 0, 0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 1, 32'h0,   32'h0);
        vecs[11] = mk(1, 1, 2, 1, 0, 0, 32'h0,    0, 0, 0, 32'h0,    1, 1, 32'h101, 32'h102);
        vecs[12] = mk(0, 0, 0, 1, 0, 0, 32'h0,    0, 0, 0, 32'h0,    1, 1, 32'h0,   32'h0);
        vecs[13] = mk(0, 0, 0, 1, 0, 0, 32'h0,    0, 0, 0, 32'h0,    1, 0, 32'h0,   32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("reset op_valid", 32'(op_valid), 32'd0);
        check("reset d_ready", 32'(d_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < int'(N_VEC); i++) run_vec(i, vecs[i]);

        // Reset while an instruction is held: output drops at once.
        run_vec(100, mk(1, 3, 4, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 32'h11, 32'h22));
        @(negedge clk);
        drive(mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0));
        #2;
        check("hold op_valid", 32'(op_valid), 32'd1);
        check_operands("hold");
        #1 rst_n = 1'b0;
        #1;
        check("midreset op_valid", 32'(op_valid), 32'd0);
        check("midreset d_ready", 32'(d_ready), 32'd1);
        sb.delete();
        m_hold1 = '0; m_hold2 = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(101, mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 32'h0));
        run_vec(102, mk(1, 1, 2, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 32'h101, 32'h102));
        run_vec(103, mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 1, 32'h0, 32'h0));
        run_vec(104, mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 32'h0));

        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
